// File: rtl/inst_fetch_queue_if.sv
// Bundles the instruction-bus, redirect and decode-side handshake signals of inst_fetch_queue.
// master = the fetch queue itself, slave = its environment (bus, EX stage, decode).
interface inst_fetch_queue_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    modport master (
        output inst_req, inst_addr, out_valid, out_pc, out_inst,
        input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  inst_req, inst_addr, out_valid, out_pc, out_inst,
        output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC, credit-limited bus requests, in-order FIFO to decode.
// Optional IFQ_BYPASS_EN lets a response reach decode in the same cycle when the FIFO is empty.
module inst_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic             clk,
    input  logic             reset,
    inst_fetch_queue_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] inst_mem [DEPTH];

    logic        accept;
    logic        resp;
    logic        resp_live;
    logic        fifo_empty;
    logic        bypass_hit;
    logic        push;
    logic        pop;
    logic [CW:0] credit_used;

    // Outstanding requests plus buffered words never exceed DEPTH, so a response always finds room.
    assign credit_used  = {1'b0, outstanding_q} + {1'b0, count_q};
    assign bus.inst_req  = ~reset & ~bus.redirect_valid & (credit_used < DEPTH_C);
    assign bus.inst_addr = fetch_pc_q;

    assign accept     = bus.inst_req & bus.inst_addr_ok;
    assign resp       = bus.inst_data_ok & (outstanding_q != '0);
    assign resp_live  = resp & (discard_q == '0);
    assign fifo_empty = (count_q == '0);

`ifdef IFQ_BYPASS_EN
    assign bypass_hit = fifo_empty & resp_live & ~bus.redirect_valid;
`else
    assign bypass_hit = 1'b0;
`endif

    assign pop  = ~bus.redirect_valid & ~fifo_empty & bus.out_ready;
    assign push = ~bus.redirect_valid & resp_live & ~(bypass_hit & bus.out_ready);

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_pc    = '0;
        bus.out_inst  = '0;
        if (!fifo_empty) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = pc_mem[rd_ptr_q];
            bus.out_inst  = inst_mem[rd_ptr_q];
        end else if (bypass_hit) begin
            bus.out_valid = 1'b1;
            bus.out_pc    = resp_pc_q;
            bus.out_inst  = bus.inst_rdata;
        end
    end

    // resp_pc tracks the PC of the next response that will survive discarding; responses are in order.
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        outstanding_d = outstanding_q + CW'(accept) - CW'(resp);
        discard_d     = discard_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            resp_pc_d  = bus.redirect_pc;
            discard_d  = outstanding_d;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (resp && !resp_live) begin
                discard_d = discard_q - CW'(1);
            end
            if (resp_live) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= resp_pc_q;
            inst_mem[wr_ptr_q] <= bus.inst_rdata;
        end
    end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch front end sitting directly upstream of the pipeline's IF/ID register.
- Owns the sequential fetch PC and issues requests on an SRAM-like instruction bus (req/addr_ok, data_ok).
- Buffers returned instructions in an in-order FIFO and presents them to decode with a valid/ready handshake.
- Handles branch redirects from EX: it flushes the FIFO and discards stale in-flight responses.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2; also caps outstanding requests plus buffered entries.
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- inst_req  output  1  request valid on instruction bus
- inst_addr  output  32  request address (current fetch_pc)
- inst_addr_ok  input  1  request accepted this cycle (handshake = inst_req & inst_addr_ok)
- inst_data_ok  input  1  one response returned this cycle; responses arrive in request order
- inst_rdata  input  32  response instruction word
- redirect_valid  input  1  branch/jump taken in EX
- redirect_pc  input  32  redirect target
- out_valid  output  1  instruction available to decode
- out_pc  output  32  PC of head instruction
- out_inst  output  32  head instruction word
- out_ready  input  1  decode accepts head (low = stall/bubble)

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high. All state changes occur on posedge clk.
- Reset values: fetch_pc=RESET_PC, FIFO empty, out_valid=0, out_pc=0, out_inst=0, inst_req=0, outstanding=0, discard=0.
- Counter widths: outstanding and discard are $clog2(DEPTH+1) bits; FIFO count is likewise sized to DEPTH+1.
- Credit rule: inst_req = ~reset & ~redirect_valid & (outstanding + fifo_count < DEPTH). This guarantees no response ever finds the FIFO full.
- inst_addr = fetch_pc, and is held stable while inst_req=1 and inst_addr_ok=0.
- On accept (inst_req & inst_addr_ok): fetch_pc += 4 (32-bit wrap, no trap) and outstanding += 1. Each FIFO entry stores the PC of the request it answers, tagged by an internal in-order PC queue or an equivalent PC-at-accept record.
- Response handling:
  - inst_data_ok with discard>0: drop the word, discard -= 1.
  - Otherwise: push {pc, inst_rdata} into the FIFO.
  - In both cases outstanding -= 1.
- Pop: when out_valid & out_ready, the head is removed. Push and pop in the same cycle are both performed; count is unchanged.
- Output path: out_valid/out_pc/out_inst are driven from the FIFO head. Minimum latency from data_ok to out_valid is 1 cycle.
- Redirect (redirect_valid=1):
  - FIFO is flushed; out_valid=0 the next cycle.
  - A pop in the same cycle is ignored.
  - fetch_pc <= redirect_pc.
  - discard <= outstanding_next, where outstanding_next = outstanding + accept − data_ok.
  - A data_ok in the redirect cycle is dropped.
  - inst_req is forced 0 in the redirect cycle, so no stale address is accepted.
  - The first request to redirect_pc issues the following cycle.
- Back-to-back redirects: the later one wins, and discard is recomputed each time.
- inst_data_ok with outstanding==0 is a protocol error; it is ignored and counters do not underflow.
- Reset mid-operation clears every counter. Responses to pre-reset requests are not tracked; the bus is also reset with the core.

Optional Feature:
- IFQ_BYPASS_EN
  - Defined: when the FIFO is empty, discard==0, no redirect, and inst_data_ok=1, out_valid/out_pc/out_inst are driven combinationally from the response (0-cycle latency). If out_ready=1 the word is consumed and not pushed; otherwise it is pushed.
  - Undefined: all responses pass through the FIFO (1-cycle latency).

Test Plan:
- Reset release, bus always ready, 1-cycle response, out_ready=1 -> inst_addr sequence 1c000000, 1c000004, 1c000008…; out_pc tracks the same values; throughput 1 per cycle after warm-up.
- out_ready=0 held for 10 cycles (DEPTH=4) -> at most 4 requests accepted, then inst_req=0. On release, the first out_pc=1c000000, in order, with no loss or duplication.
- 2 requests outstanding, then redirect_valid with redirect_pc=1c000100 -> both stale responses dropped, FIFO empty; the next out_pc=1c000100 and the next inst_addr=1c000100.
- redirect_valid coincident with inst_data_ok and inst_addr_ok -> the response is dropped and discard equals the remaining outstanding; no stale PC ever reaches out_pc.
- inst_addr_ok held low 3 cycles -> inst_addr held at 1c000000, fetch_pc does not advance.
- IFQ_BYPASS_EN defined, empty FIFO, data_ok with inst_rdata=02800421 -> out_valid=1 and out_inst=02800421 in the same cycle; with the macro undefined, both appear one cycle later.
